// File: rtl/read_response_generator.sv
// AXI read-channel responder. AR requests are buffered in a small FIFO and
// replayed as INCR R bursts. Each beat's data is {beat index, beat address},
// so the receiver can check every beat without a memory model. Beats at or
// above MEM_LIMIT return SLVERR.
module read_response_generator #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int TAG_WIDTH  = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int REQ_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] MEM_LIMIT = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    input  logic [ID_WIDTH-1:0]   ar_id,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic [LEN_WIDTH-1:0]  ar_len,
    input  logic [TAG_WIDTH-1:0]  ar_tagid,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [ID_WIDTH-1:0]   r_id,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [RESP_WIDTH-1:0] r_resp,
    output logic                  r_last,
    output logic [TAG_WIDTH-1:0]  r_tagid,
    output logic                  busy
);

    localparam int PTR_W = $clog2(REQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(REQ_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY  = RESP_WIDTH'(2'b00);
    localparam logic [RESP_WIDTH-1:0] RESP_SLV   = RESP_WIDTH'(2'b10);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Request queue storage
    logic [ID_WIDTH-1:0]   q_id_r   [REQ_DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr_r [REQ_DEPTH];
    logic [LEN_WIDTH-1:0]  q_len_r  [REQ_DEPTH];
    logic [TAG_WIDTH-1:0]  q_tag_r  [REQ_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]      count_r, count_s;
    logic                  pend_r;
    logic                  ar_ready_r, busy_r;
    logic                  push_s, pop_s;

    // Burst state; the r_* outputs are driven straight from these registers
    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] beat_addr_r, beat_addr_s;
    logic [LEN_WIDTH-1:0]  beat_idx_r, beat_idx_s;
    logic [LEN_WIDTH-1:0]  len_r, len_s;
    logic [ID_WIDTH-1:0]   r_id_r, r_id_s;
    logic [TAG_WIDTH-1:0]  r_tag_r, r_tag_s;
    logic                  r_valid_r, r_valid_s;
    logic                  r_last_r, r_last_s;
    logic [RESP_WIDTH-1:0] r_resp_r, r_resp_s;
    logic [DATA_WIDTH-1:0] r_data_r, r_data_s;

    // Slave response code for a beat address
    function automatic logic [RESP_WIDTH-1:0] beat_resp(input logic [ADDR_WIDTH-1:0] addr);
        if (addr < MEM_LIMIT) begin
            beat_resp = RESP_OKAY;
        end else begin
            beat_resp = RESP_SLV;
        end
    endfunction

    // ar_ready reflects the registered not-full state, so a pop never frees room for a same-cycle push
    assign push_s = ar_valid && ar_ready_r;

    // Queue occupancy bookkeeping
    always_comb begin
        count_s = count_r;
        if (push_s && !pop_s) begin
            count_s = count_r + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            count_s = count_r - CNT_W'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Burst sequencer: next state, head pop and next beat fields
    always_comb begin
        state_s     = state_r;
        pop_s       = 1'b0;
        beat_addr_s = beat_addr_r;
        beat_idx_s  = beat_idx_r;
        len_s       = len_r;
        r_id_s      = r_id_r;
        r_tag_s     = r_tag_r;
        r_valid_s   = r_valid_r;
        case (state_r)
            ST_IDLE: begin
                // pend_r delays the first pop by one cycle, giving the AR-to-R latency of two edges
                if (pend_r && (count_r != CNT_W'(0))) begin
                    pop_s   = 1'b1;
                    state_s = ST_BURST;
                end else begin
                    r_valid_s = 1'b0;
                end
            end
            ST_BURST: begin
                if (r_ready) begin
                    if (beat_idx_r == len_r) begin
                        if (count_r != CNT_W'(0)) begin
                            pop_s = 1'b1;
                        end else begin
                            state_s   = ST_IDLE;
                            r_valid_s = 1'b0;
                        end
                    end else begin
                        beat_idx_s  = beat_idx_r + LEN_WIDTH'(1);
                        beat_addr_s = beat_addr_r + BEAT_BYTES;
                    end
                end else begin
                    state_s = ST_BURST;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                r_valid_s = 1'b0;
            end
        endcase
        if (pop_s) begin
            beat_addr_s = q_addr_r[rd_ptr_r];
            beat_idx_s  = LEN_WIDTH'(0);
            len_s       = q_len_r[rd_ptr_r];
            r_id_s      = q_id_r[rd_ptr_r];
            r_tag_s     = q_tag_r[rd_ptr_r];
            r_valid_s   = 1'b1;
        end else begin
            r_valid_s = r_valid_s;
        end
    end

    // Beat payload derived from the next beat address and index
    always_comb begin
        r_data_s = '0;
        r_data_s[ADDR_WIDTH-1:0] = beat_addr_s;
        r_data_s[ADDR_WIDTH +: LEN_WIDTH] = beat_idx_s;
        r_resp_s = beat_resp(beat_addr_s);
        if (r_valid_s) begin
            r_last_s = (beat_idx_s == len_s);
        end else begin
            r_last_s = 1'b0;
        end
    end

    // Queue payload write; storage is qualified by the pointers so it needs no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_id_r[wr_ptr_r]   <= ar_id;
            q_addr_r[wr_ptr_r] <= ar_addr;
            q_len_r[wr_ptr_r]  <= ar_len;
            q_tag_r[wr_ptr_r]  <= ar_tagid;
        end
    end

    // Queue pointers, occupancy and handshake/status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            pend_r     <= 1'b0;
            ar_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r    <= count_s;
            pend_r     <= (count_r != CNT_W'(0));
            ar_ready_r <= (count_s != DEPTH_C);
            busy_r     <= (state_s == ST_BURST) || (count_s != CNT_W'(0));
        end
    end

    // FSM state and registered R-channel outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            beat_addr_r <= '0;
            beat_idx_r  <= '0;
            len_r       <= '0;
            r_id_r      <= '0;
            r_tag_r     <= '0;
            r_valid_r   <= 1'b0;
            r_last_r    <= 1'b0;
            r_resp_r    <= '0;
            r_data_r    <= '0;
        end else begin
            state_r     <= state_s;
            beat_addr_r <= beat_addr_s;
            beat_idx_r  <= beat_idx_s;
            len_r       <= len_s;
            r_id_r      <= r_id_s;
            r_tag_r     <= r_tag_s;
            r_valid_r   <= r_valid_s;
            r_last_r    <= r_last_s;
            r_resp_r    <= r_resp_s;
            r_data_r    <= r_data_s;
        end
    end

    assign ar_ready = ar_ready_r;
    assign busy     = busy_r;
    assign r_valid  = r_valid_r;
    assign r_id     = r_id_r;
    assign r_tagid  = r_tag_r;
    assign r_data   = r_data_r;
    assign r_resp   = r_resp_r;
    assign r_last   = r_last_r;

endmodule

// File: tb/tb_read_response_generator.sv
// Self-checking bench for read_response_generator. Accepted AR requests are
// expanded into expected beats on a scoreboard queue; every R handshake pops
// and compares one beat. Directed checks cover reset, latency, backpressure,
// queue-full, SLVERR boundary, back-to-back bursts and reset mid-burst.
module tb_read_response_generator;

    typedef struct packed {
        logic [3:0]  id;
        logic [3:0]  tag;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [3:0]  ar_id = 4'd0;
    logic [31:0] ar_addr = 32'd0;
    logic [7:0]  ar_len = 8'd0;
    logic [3:0]  ar_tagid = 4'd0;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [3:0]  r_tagid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_beats  = 0;
    int n_acc    = 0;
    beat_t exp_q[$];

    read_response_generator dut (
        .clk(clk), .rst(rst),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id),
        .ar_addr(ar_addr), .ar_len(ar_len), .ar_tagid(ar_tagid),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last), .r_tagid(r_tagid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard push on AR handshake, compare on R handshake, stall stability
    logic        stall_pend = 1'b0;
    logic [63:0] stall_data;
    logic [63:0] stall_meta;
    always @(negedge clk) begin
        if (!rst) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check_eq("stall_data", r_data, stall_data);
                check_eq("stall_meta", {r_valid, r_id, r_tagid, r_resp, r_last}, stall_meta);
            end
            if (r_valid && r_ready) begin
                n_beats++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_beat", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check_eq("r_data", r_data, e.data);
                    check_eq("r_meta", {r_id, r_tagid, r_resp, r_last},
                             {e.id, e.tag, e.resp, e.last});
                end
            end
            stall_pend = r_valid && !r_ready;
            stall_data = r_data;
            stall_meta = {59'd0, r_valid, r_id, r_tagid, r_resp, r_last};
            if (ar_valid && ar_ready) begin
                n_acc++;
                for (int i = 0; i <= int'(ar_len); i++) begin
                    beat_t e;
                    logic [31:0] a;
                    a = ar_addr + 32'(i * 8);
                    e.id   = ar_id;
                    e.tag  = ar_tagid;
                    e.data = {24'd0, 8'(i), a};
                    e.resp = (a < 32'h0001_0000) ? 2'b00 : 2'b10;
                    e.last = (i == int'(ar_len));
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Issue one AR and return one step after the handshake edge
    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [3:0] tag);
        bit ok = 1'b0;
        ar_id = id; ar_addr = addr; ar_len = len; ar_tagid = tag;
        ar_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (ar_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        ar_valid = 1'b0;
        if (!ok) check_eq("ar_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && !r_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("idle_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_rvalid();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (r_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("rvalid_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int b0, a0, seen;
        // Reset values
        #1 rst = 1'b0;
        #13;
        check_eq("rst_outputs", {r_valid, r_last, r_id, r_tagid, r_resp, busy, ar_ready}, 64'd0);
        check_eq("rst_data", r_data, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        check_eq("ar_ready_pre", {63'd0, ar_ready}, 64'd0);
        @(posedge clk); #1;
        check_eq("ar_ready_post", {63'd0, ar_ready}, 64'd1);

        // Single beat with latency
        r_ready = 1'b1;
        send_ar(4'd3, 32'h100, 8'd0, 4'd5);
        @(negedge clk);
        check_eq("lat_n1_valid", {63'd0, r_valid}, 64'd0);
        check_eq("lat_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check_eq("lat_n2_valid", {63'd0, r_valid}, 64'd0);
        @(negedge clk);
        check_eq("lat_n3_valid", {63'd0, r_valid}, 64'd1);
        check_eq("single_data", r_data, 64'h0000_0000_0000_0100);
        @(negedge clk);
        check_eq("single_done", {62'd0, busy, r_valid}, 64'd0);
        @(posedge clk); #1;

        // Burst with toggling backpressure
        b0 = n_beats;
        send_ar(4'd6, 32'h1000, 8'd3, 4'd2);
        for (int i = 0; i < 24; i++) begin
            r_ready = ~r_ready;
            @(posedge clk); #1;
        end
        r_ready = 1'b1;
        wait_idle();
        check_eq("bp_beats", 64'(n_beats - b0), 64'd4);

        // Queue full: five accepted while stalled, sixth after a burst completes
        r_ready = 1'b0;
        a0 = n_acc;
        b0 = n_beats;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send_ar(4'(k), 32'h2000 + 32'(k * 256), 8'd1, 4'(k + 8));
                end
            end
        join_none
        repeat (14) @(posedge clk);
        #1;
        check_eq("full_accepted", 64'(n_acc - a0), 64'd5);
        check_eq("full_ar_ready", {63'd0, ar_ready}, 64'd0);
        r_ready = 1'b1;
        wait fork;
        wait_idle();
        check_eq("full_total_acc", 64'(n_acc - a0), 64'd6);
        check_eq("full_beats", 64'(n_beats - b0), 64'd12);

        // SLVERR boundary
        b0 = n_beats;
        send_ar(4'd7, 32'h0000_FFF8, 8'd1, 4'd1);
        wait_idle();
        check_eq("err_beats", 64'(n_beats - b0), 64'd2);

        // Back-to-back bursts without a bubble
        r_ready = 1'b0;
        send_ar(4'd1, 32'h3000, 8'd1, 4'd3);
        send_ar(4'd2, 32'h4000, 8'd1, 4'd4);
        wait_rvalid();
        r_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (r_valid) seen++;
        end
        check_eq("b2b_valid_cycles", 64'(seen), 64'd4);
        @(negedge clk);
        check_eq("b2b_end", {63'd0, r_valid}, 64'd0);
        wait_idle();

        // Reset during beat 2 of a long burst with two requests queued
        r_ready = 1'b0;
        send_ar(4'd9, 32'h5000, 8'd7, 4'd6);
        send_ar(4'd10, 32'h6000, 8'd0, 4'd7);
        send_ar(4'd11, 32'h7000, 8'd0, 4'd8);
        wait_rvalid();
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_outputs", {r_valid, r_last, busy, ar_ready}, 64'd0);
        check_eq("mid_rst_data", r_data, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        r_ready = 1'b1;
        b0 = n_beats;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (r_valid) seen++;
        end
        check_eq("post_rst_stale", 64'(seen + n_beats - b0), 64'd0);
        check_eq("post_rst_status", {62'd0, busy, ar_ready}, 64'd1);

        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
